// File: rtl/iommu_ddtc_ctrl.sv
// IOMMU DDTC controller: lookup, single-level DDT fetch/fill, INVAL_DDT flush.
// The extended device context type is kept here so the block stays self-contained.
package iommu_pkg;

    typedef struct packed {
        logic [63:0] rsvd;
        logic [63:0] msi_addr_pattern;
        logic [63:0] msi_addr_mask;
        logic [63:0] msiptp;
        logic [63:0] fsc;
        logic [63:0] ta;
        logic [63:0] iohgatp;
        logic [63:0] tc;
    } dc_ext_t;

endpackage

module iommu_ddtc_ctrl
    import iommu_pkg::*;
#(
    parameter int unsigned DEVICE_ID_WIDTH = 6,
    parameter int unsigned DC_BEATS        = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [DEVICE_ID_WIDTH-1:0] req_did_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output dc_ext_t                    rsp_dc_o,
    output logic                       rsp_fault_o,
    input  logic                       inval_valid_i,
    output logic                       inval_ready_o,
    input  logic                       inval_dv_i,
    input  logic [DEVICE_ID_WIDTH-1:0] inval_did_i,
    input  logic [43:0]                ddtp_ppn_i,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic [55:0]                mem_addr_o,
    input  logic                       mem_rvalid_i,
    input  logic [63:0]                mem_rdata_i,
    input  logic                       mem_err_i,
    output logic                       ddtc_flush_o,
    output logic                       ddtc_flush_dv_o,
    output logic [DEVICE_ID_WIDTH-1:0] ddtc_flush_did_o,
    output logic                       ddtc_update_o,
    output logic [DEVICE_ID_WIDTH-1:0] ddtc_up_did_o,
    output dc_ext_t                    ddtc_up_content_o,
    output logic                       ddtc_lookup_o,
    output logic [DEVICE_ID_WIDTH-1:0] ddtc_lu_did_o,
    input  dc_ext_t                    ddtc_lu_content_i,
    input  logic                       ddtc_lu_hit_i
);

    localparam int unsigned CNT_W = $clog2(DC_BEATS);
    localparam int unsigned DC_W  = DC_BEATS * 64;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_DATA,
        UPDATE,
        RESP
    } state_e;

    state_e                       state_q, state_d;
    logic [DEVICE_ID_WIDTH-1:0]   did_q, did_d;
    logic [DC_W-1:0]              dc_q, dc_d;
    logic [55:0]                  addr_q, addr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic                         fault_q, fault_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            did_q   <= '0;
            dc_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            did_q   <= did_d;
            dc_q    <= dc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        did_d         = did_q;
        dc_d          = dc_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        fault_d       = fault_q;
        req_ready_o   = 1'b0;
        inval_ready_o = 1'b0;
        ddtc_flush_o  = 1'b0;
        ddtc_lookup_o = 1'b0;
        ddtc_lu_did_o = '0;

        unique case (state_q)
            IDLE: begin
                // Invalidations win so a flush never races a fresh lookup.
                if (inval_valid_i) begin
                    inval_ready_o = 1'b1;
                    ddtc_flush_o  = 1'b1;
                end else if (req_valid_i) begin
                    req_ready_o   = 1'b1;
                    ddtc_lookup_o = 1'b1;
                    ddtc_lu_did_o = req_did_i;
                    did_d         = req_did_i;
                    cnt_d         = '0;
                    err_d         = 1'b0;
                    fault_d       = 1'b0;
                    if (ddtc_lu_hit_i) begin
                        dc_d    = DC_W'(ddtc_lu_content_i);
                        state_d = RESP;
                    end else begin
                        addr_d  = {ddtp_ppn_i, 12'b0} + 56'({req_did_i, 6'b0});
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    state_d = MEM_DATA;
                end
            end
            MEM_DATA: begin
                if (mem_rvalid_i) begin
                    dc_d[{cnt_q, 6'b0} +: 64] = mem_rdata_i;
                    err_d = err_q | mem_err_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DC_BEATS - 1)) begin
                        if (err_d || !dc_d[0]) begin
                            fault_d = 1'b1;
                            state_d = RESP;
                        end else begin
                            state_d = UPDATE;
                        end
                    end
                end
            end
            UPDATE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ddtc_flush_dv_o   = inval_dv_i;
    assign ddtc_flush_did_o  = inval_did_i;
    assign mem_req_o         = (state_q == MEM_REQ);
    assign mem_addr_o        = addr_q;
    assign ddtc_update_o     = (state_q == UPDATE);
    assign ddtc_up_did_o     = did_q;
    assign ddtc_up_content_o = dc_ext_t'(dc_q);
    assign rsp_valid_o       = (state_q == RESP);
    assign rsp_fault_o       = rsp_valid_o & fault_q;
    assign rsp_dc_o          = (rsp_valid_o && !fault_q) ? dc_ext_t'(dc_q) : '0;

endmodule

// File: tb/tb_iommu_ddtc_ctrl.sv
// Directed bench for iommu_ddtc_ctrl with a small behavioural DDTC.
module tb_iommu_ddtc_ctrl;
    import iommu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  req_did_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    dc_ext_t     rsp_dc_o;
    logic        rsp_fault_o;
    logic        inval_valid_i = 1'b0;
    logic        inval_ready_o;
    logic        inval_dv_i = 1'b0;
    logic [5:0]  inval_did_i = '0;
    logic [43:0] ddtp_ppn_i = 44'h80000;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [55:0] mem_addr_o;
    logic        mem_rvalid_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        ddtc_flush_o;
    logic        ddtc_flush_dv_o;
    logic [5:0]  ddtc_flush_did_o;
    logic        ddtc_update_o;
    logic [5:0]  ddtc_up_did_o;
    dc_ext_t     ddtc_up_content_o;
    logic        ddtc_lookup_o;
    logic [5:0]  ddtc_lu_did_o;
    dc_ext_t     ddtc_lu_content_i;
    logic        ddtc_lu_hit_i;

    iommu_ddtc_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_did_i(req_did_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dc_o(rsp_dc_o), .rsp_fault_o(rsp_fault_o),
        .inval_valid_i(inval_valid_i), .inval_ready_o(inval_ready_o),
        .inval_dv_i(inval_dv_i), .inval_did_i(inval_did_i),
        .ddtp_ppn_i(ddtp_ppn_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_err_i(mem_err_i),
        .ddtc_flush_o(ddtc_flush_o), .ddtc_flush_dv_o(ddtc_flush_dv_o),
        .ddtc_flush_did_o(ddtc_flush_did_o),
        .ddtc_update_o(ddtc_update_o), .ddtc_up_did_o(ddtc_up_did_o),
        .ddtc_up_content_o(ddtc_up_content_o),
        .ddtc_lookup_o(ddtc_lookup_o), .ddtc_lu_did_o(ddtc_lu_did_o),
        .ddtc_lu_content_i(ddtc_lu_content_i),
        .ddtc_lu_hit_i(ddtc_lu_hit_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural DDTC: fully associative by device_id.
    logic        cache_v [64];
    dc_ext_t     cache_dc [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_did = '0;
    dc_ext_t     pre_dc = '0;
    int          upd_cnt = 0;

    assign ddtc_lu_hit_i     = ddtc_lookup_o && cache_v[ddtc_lu_did_o];
    assign ddtc_lu_content_i = cache_dc[ddtc_lu_did_o];

    always @(posedge clk_i) begin
        if (pre_we) begin
            for (int i = 0; i < 64; i++) cache_v[i] <= 1'b0;
            cache_v[pre_did]  <= 1'b1;
            cache_dc[pre_did] <= pre_dc;
        end else begin
            if (ddtc_update_o) begin
                cache_v[ddtc_up_did_o]  <= 1'b1;
                cache_dc[ddtc_up_did_o] <= ddtc_up_content_o;
                upd_cnt = upd_cnt + 1;
            end
            if (ddtc_flush_o) begin
                if (ddtc_flush_dv_o) cache_v[ddtc_flush_did_o] <= 1'b0;
                else for (int i = 0; i < 64; i++) cache_v[i] <= 1'b0;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] beat(input int k, input logic [7:0] salt,
                                         input logic v);
        return {16'hBEEF, salt, 8'(k), 31'h1234, v};
    endfunction

    function automatic logic [511:0] dc_img(input logic [7:0] salt,
                                            input logic v);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = beat(k, salt, k == 0 ? v : 1'b0);
        return r;
    endfunction

    // Drive 8 beats, one per cycle, optional error on beat errk.
    task automatic feed(input logic [7:0] salt, input logic v, input int errk);
        for (int k = 0; k < 8; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = beat(k, salt, k == 0 ? v : 1'b0);
            mem_err_i    = (k == errk);
            step();
        end
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
    endtask

    logic [511:0] exp_dc;
    logic [511:0] hold_dc;
    int           u0;

    initial begin
        pre_did = 6'd5;
        pre_dc  = dc_ext_t'({448'h0, 64'hCAFE_0000_0000_0011});
        pre_we  = 1'b1;
        #2;
        chk("rst_rsp_valid", 512'(rsp_valid_o), 512'(0));
        chk("rst_mem_req", 512'(mem_req_o), 512'(0));
        chk("rst_update", 512'(ddtc_update_o), 512'(0));
        chk("rst_rsp_dc", rsp_dc_o, 512'(0));
        chk("rst_addr", 512'(mem_addr_o), 512'(0));
        step();
        step();
        pre_we = 1'b0;
        rst_ni = 1'b1;
        step();

        // Hit on did=5
        req_valid_i = 1'b1;
        req_did_i   = 6'd5;
        #1;
        chk("hit_req_ready", 512'(req_ready_o), 512'(1));
        chk("hit_lookup", 512'(ddtc_lookup_o), 512'(1));
        chk("hit_lu_did", 512'(ddtc_lu_did_o), 512'(5));
        step();
        req_valid_i = 1'b0;
        chk("hit_rsp_valid", 512'(rsp_valid_o), 512'(1));
        chk("hit_rsp_dc", rsp_dc_o, {448'h0, 64'hCAFE_0000_0000_0011});
        chk("hit_fault", 512'(rsp_fault_o), 512'(0));
        chk("hit_no_mem", 512'(mem_req_o), 512'(0));
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("hit_done", 512'(rsp_valid_o), 512'(0));

        // Miss on did=3, grant after 2 cycles
        u0 = upd_cnt;
        req_valid_i = 1'b1;
        req_did_i   = 6'd3;
        #1;
        chk("miss_lookup", 512'(ddtc_lookup_o), 512'(1));
        step();
        req_valid_i = 1'b0;
        chk("miss_mem_req", 512'(mem_req_o), 512'(1));
        chk("miss_addr", 512'(mem_addr_o), 512'(56'h00_0000_8000_00C0));
        chk("miss_busy_ready", 512'(req_ready_o), 512'(0));
        step();
        step();
        chk("miss_req_held", 512'(mem_req_o), 512'(1));
        chk("miss_addr_held", 512'(mem_addr_o), 512'(56'h00_0000_8000_00C0));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("miss_req_drop", 512'(mem_req_o), 512'(0));
        feed(8'h33, 1'b1, -1);
        exp_dc = dc_img(8'h33, 1'b1);
        chk("miss_update", 512'(ddtc_update_o), 512'(1));
        chk("miss_up_did", 512'(ddtc_up_did_o), 512'(3));
        chk("miss_up_dc", ddtc_up_content_o, exp_dc);
        chk("miss_no_rsp_yet", 512'(rsp_valid_o), 512'(0));
        step();
        chk("miss_update_1cyc", 512'(ddtc_update_o), 512'(0));
        chk("miss_rsp_valid", 512'(rsp_valid_o), 512'(1));
        chk("miss_rsp_dc", rsp_dc_o, exp_dc);
        chk("miss_fault", 512'(rsp_fault_o), 512'(0));
        chk("miss_upd_cnt", 512'(upd_cnt - u0), 512'(1));
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Repeat did=3 now hits
        req_valid_i = 1'b1;
        req_did_i   = 6'd3;
        step();
        req_valid_i = 1'b0;
        chk("rehit_rsp_valid", 512'(rsp_valid_o), 512'(1));
        chk("rehit_no_mem", 512'(mem_req_o), 512'(0));
        chk("rehit_dc", rsp_dc_o, exp_dc);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Miss with bus error on beat 4
        u0 = upd_cnt;
        req_valid_i = 1'b1;
        req_did_i   = 6'd7;
        step();
        req_valid_i = 1'b0;
        chk("err_addr", 512'(mem_addr_o), 512'(56'h00_0000_8000_01C0));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        feed(8'h77, 1'b1, 4);
        chk("err_rsp_valid", 512'(rsp_valid_o), 512'(1));
        chk("err_fault", 512'(rsp_fault_o), 512'(1));
        chk("err_dc_zero", rsp_dc_o, 512'(0));
        chk("err_no_update", 512'(upd_cnt - u0), 512'(0));
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Miss with tc.v=0
        u0 = upd_cnt;
        req_valid_i = 1'b1;
        req_did_i   = 6'd9;
        step();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        feed(8'h99, 1'b0, -1);
        chk("tcv_rsp_valid", 512'(rsp_valid_o), 512'(1));
        chk("tcv_fault", 512'(rsp_fault_o), 512'(1));
        chk("tcv_dc_zero", rsp_dc_o, 512'(0));
        chk("tcv_no_update", 512'(upd_cnt - u0), 512'(0));
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        // Invalidation and request together: flush first
        inval_valid_i = 1'b1;
        inval_dv_i    = 1'b1;
        inval_did_i   = 6'd3;
        req_valid_i   = 1'b1;
        req_did_i     = 6'd3;
        #1;
        chk("both_inval_ready", 512'(inval_ready_o), 512'(1));
        chk("both_flush", 512'(ddtc_flush_o), 512'(1));
        chk("both_flush_dv", 512'(ddtc_flush_dv_o), 512'(1));
        chk("both_flush_did", 512'(ddtc_flush_did_o), 512'(3));
        chk("both_req_blocked", 512'(req_ready_o), 512'(0));
        chk("both_no_lookup", 512'(ddtc_lookup_o), 512'(0));
        step();
        inval_valid_i = 1'b0;
        #1;
        chk("both_req_next", 512'(req_ready_o), 512'(1));
        step();
        req_valid_i = 1'b0;
        chk("both_misses", 512'(mem_req_o), 512'(1));

        // Invalidation raised mid-walk waits for RESP to finish
        inval_valid_i = 1'b1;
        #1;
        chk("mid_inval_wait", 512'(inval_ready_o), 512'(0));
        chk("mid_no_flush", 512'(ddtc_flush_o), 512'(0));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        chk("mid_inval_wait2", 512'(inval_ready_o), 512'(0));
        feed(8'h3C, 1'b1, -1);
        step();
        exp_dc = dc_img(8'h3C, 1'b1);
        hold_dc = rsp_dc_o;
        chk("stall_dc", hold_dc, exp_dc);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 512'(rsp_valid_o), 512'(1));
            chk("stall_dc_stable", rsp_dc_o, hold_dc);
            chk("stall_req_ready", 512'(req_ready_o), 512'(0));
            chk("stall_inval_ready", 512'(inval_ready_o), 512'(0));
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("post_resp_flush", 512'(ddtc_flush_o), 512'(1));
        chk("post_resp_inval", 512'(inval_ready_o), 512'(1));
        step();
        inval_valid_i = 1'b0;

        // Flush removed the fill: did=3 misses; then reset in MEM_DATA
        u0 = upd_cnt;
        req_valid_i = 1'b1;
        req_did_i   = 6'd3;
        step();
        req_valid_i = 1'b0;
        chk("stale_removed", 512'(mem_req_o), 512'(1));
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = beat(0, 8'h55, 1'b1);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_req", 512'(mem_req_o), 512'(0));
        chk("rst_mid_rsp", 512'(rsp_valid_o), 512'(0));
        chk("rst_mid_upd", 512'(ddtc_update_o), 512'(0));
        chk("rst_mid_addr", 512'(mem_addr_o), 512'(0));
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("late_beat_rsp", 512'(rsp_valid_o), 512'(0));
            chk("late_beat_upd", 512'(ddtc_update_o), 512'(0));
        end
        mem_rvalid_i = 1'b0;
        chk("late_upd_cnt", 512'(upd_cnt - u0), 512'(0));
        req_valid_i = 1'b1;
        req_did_i   = 6'd5;
        #1;
        chk("after_rst_ready", 512'(req_ready_o), 512'(1));
        step();
        req_valid_i = 1'b0;
        chk("after_rst_hit", 512'(rsp_valid_o), 512'(1));
        chk("after_rst_dc", rsp_dc_o, {448'h0, 64'hCAFE_0000_0000_0011});
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
